// File: rtl/lsu.sv
// Load/store unit: issues one RV32I load or store at a time to the ram data port.
// Aligned accesses use a single ram access; misaligned halfwords and words are
// split into sequential byte accesses. Illegal or out-of-range requests fault
// without touching memory.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/ready/write/funct3  request handshake and type
//   req_addr, req_wdata           byte address and store data
//   resp_valid/rdata/fault        single-cycle response
//   mem_addr/d_size/w_en/u_en     ram data-side control
//   mem_d_in, mem_d_out           ram store data / registered load data
module lsu #(
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [13:0] mem_addr,
    output logic [1:0]  mem_d_size,
    output logic        mem_w_en,
    output logic        mem_u_en,
    output logic [31:0] mem_d_in,
    input  logic [31:0] mem_d_out
);

    localparam int unsigned AW = 14;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]    state, state_nxt;
    logic          wr_q;
    logic [2:0]    f3_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          misal_q;
    logic [1:0]    last_q;
    logic [1:0]    cnt;
    logic [31:0]   ld_buf;

    logic          accept;
    logic          illegal;
    logic          out_of_range;
    logic          fault;
    logic          misal;
    logic [1:0]    nb_m1;
    logic [32:0]   end_addr;
    logic          more;
    logic [1:0]    cnt_inc;
    logic [31:0]   merged;
    logic [31:0]   load_res;

    // Request decode: size, fault and alignment of the incoming request
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   nb_m1 = 2'd0;
            2'b01:   nb_m1 = 2'd1;
            default: nb_m1 = 2'd3;
        endcase
        illegal      = (req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11)
                       || (req_write && req_funct3[2]);
        // 33-bit sum so that addresses near 2^32 do not wrap into range
        end_addr     = {1'b0, req_addr} + 33'(nb_m1);
        out_of_range = end_addr > 33'(MEM_BYTES - 1);
        fault        = illegal || out_of_range;
        misal        = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                    || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        accept       = req_valid && req_ready;
        more         = misal_q && (cnt != last_q);
        cnt_inc      = cnt + 2'd1;
    end

    // Load result: merge current byte into the buffer, then extend
    always_comb begin
        merged = ld_buf;
        merged[{cnt, 3'b000} +: 8] = mem_d_out[7:0];
        if (!misal_q) begin
            load_res = mem_d_out;
        end else if (f3_q[1:0] == 2'b01) begin
            load_res = f3_q[2] ? {16'b0, merged[15:0]}
                               : {{16{merged[15]}}, merged[15:0]};
        end else begin
            load_res = merged;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = fault ? S_RESP : S_ACCESS;
            S_ACCESS:  state_nxt = !wr_q ? S_CAPTURE : (more ? S_ACCESS : S_RESP);
            S_CAPTURE: state_nxt = more ? S_ACCESS : S_RESP;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Request latches, memory drive, load buffer and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            mem_addr   <= '0;
            mem_d_size <= '0;
            mem_w_en   <= 1'b0;
            mem_u_en   <= 1'b0;
            mem_d_in   <= '0;
            wr_q       <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            misal_q    <= 1'b0;
            last_q     <= '0;
            cnt        <= '0;
            ld_buf     <= '0;
        end else begin
            req_ready  <= (state_nxt == S_IDLE);
            resp_valid <= 1'b0;
            mem_w_en   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        wr_q    <= req_write;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr[AW-1:0];
                        wdata_q <= req_wdata;
                        misal_q <= misal;
                        last_q  <= nb_m1;
                        cnt     <= '0;
                        ld_buf  <= '0;
                        if (fault) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            mem_addr   <= req_addr[AW-1:0];
                            mem_d_size <= misal ? 2'b00 : req_funct3[1:0];
                            mem_u_en   <= misal || req_funct3[2];
                            mem_d_in   <= misal ? {24'b0, req_wdata[7:0]} : req_wdata;
                            mem_w_en   <= req_write;
                        end
                    end
                end
                S_ACCESS, S_CAPTURE: begin
                    if (state == S_CAPTURE) ld_buf <= merged;
                    if (state == S_CAPTURE || wr_q) begin
                        if (more) begin
                            cnt      <= cnt_inc;
                            mem_addr <= addr_q + AW'(cnt_inc);
                            mem_d_in <= {24'b0, wdata_q[{cnt_inc, 3'b000} +: 8]};
                            mem_w_en <= wr_q;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b0;
                            resp_rdata <= wr_q ? 32'd0 : load_res;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
